// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
// Issue-side controller between the core's FP issue logic and the private FPU
// wrapper. It takes one request at a time, holds the operands in issue
// registers while the FPU runs, and returns the tagged result through a
// one-entry response buffer. When the response buffer is full and not
// draining, the FPU is stalled.
//
// Optional feature macro: FPU_ISSUE_TIMEOUT_EN
//   Defined: an EXEC watchdog forces a zero result with rsp_err_o=1 after
//            TIMEOUT_CYC unstalled EXEC cycles without a real result.
//   Undefined: no watchdog, and rsp_err_o is tied to 0.
//
// Handshake rules for both req_* and rsp_*:
//   - A transfer happens on a rising clk edge where valid and ready are both 1.
//   - While valid is 1 and the transfer has not happened, the payload does
//     not change.
//   - ready may depend on valid in the same cycle. Here req_ready_o depends on
//     the FPU capture in EXEC.
//
// busy_o shows the FSM state (1 = EXEC, 0 = IDLE).
module fpu_issue_ctrl #(
    parameter int OP_W        = 32,
    parameter int RM_W        = 3,
    parameter int CMD_W       = 4,
    parameter int TAG_W       = 5,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [OP_W-1:0]  req_operand_a_i,
    input  logic [OP_W-1:0]  req_operand_b_i,
    input  logic [RM_W-1:0]  req_rm_i,
    input  logic [CMD_W-1:0] req_op_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [OP_W-1:0]  rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o,
    output logic             busy_o,
    output logic             fpu_enable_o,
    output logic             fpu_stall_o,
    output logic [OP_W-1:0]  fpu_operand_a_o,
    output logic [OP_W-1:0]  fpu_operand_b_o,
    output logic [RM_W-1:0]  fpu_rm_o,
    output logic [CMD_W-1:0] fpu_op_o,
    input  logic [OP_W-1:0]  fpu_result_i,
    input  logic             fpu_ready_i,
    input  logic             fpu_result_valid_i
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [OP_W-1:0]  op_a_q;
    logic [OP_W-1:0]  op_b_q;
    logic [RM_W-1:0]  rm_q;
    logic [CMD_W-1:0] cmd_q;
    logic [TAG_W-1:0] tag_q;
    logic             rsp_valid_q;
    logic [OP_W-1:0]  rsp_result_q;
    logic [TAG_W-1:0] rsp_tag_q;

    logic in_exec;
    logic stall;
    logic force_cap;
    logic capture;
    logic accept;

    // fpu_ready_i is observed but does not take part in any control decision.
    logic unused_ok;

    assign in_exec = (state_q == ST_EXEC);
    assign stall   = in_exec & rsp_valid_q & ~rsp_ready_i;
    assign capture = in_exec & (fpu_result_valid_i | force_cap) & ~stall;
    // In EXEC, a new request is accepted only in the cycle the current
    // result is captured. This gives back-to-back issue without a bubble.
    assign req_ready_o = ~in_exec | capture;
    assign accept      = req_valid_i & req_ready_o;

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wd_cnt_q;
    logic             rsp_err_q;

    // A forced capture happens only if the FPU has no real result this cycle,
    // so a late real result still takes priority.
    assign force_cap = in_exec & ~stall & ~fpu_result_valid_i &
                       (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign unused_ok = fpu_ready_i;
    assign rsp_err_o = rsp_err_q;

    // Watchdog: counts unstalled EXEC cycles of the current operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else if (accept) begin
            wd_cnt_q <= '0;
        end else if (in_exec && !stall && !capture) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    // Error flag travels with the buffered response it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (capture) begin
            rsp_err_q <= force_cap;
        end
    end
`else
    assign force_cap = 1'b0;
    assign unused_ok = fpu_ready_i | (TIMEOUT_CYC == 0);
    assign rsp_err_o = 1'b0;
`endif

    // Next-state logic: IDLE -> EXEC on accept; EXEC -> IDLE on capture without a new accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: if (capture && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue registers: loaded only on accept, so the FPU inputs stay stable during EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q <= '0;
            op_b_q <= '0;
            rm_q   <= '0;
            cmd_q  <= '0;
            tag_q  <= '0;
        end else if (accept) begin
            op_a_q <= req_operand_a_i;
            op_b_q <= req_operand_b_i;
            rm_q   <= req_rm_i;
            cmd_q  <= req_op_i;
            tag_q  <= req_tag_i;
        end
    end

    // Response buffer. A capture is possible only when the buffer is empty or
    // being popped, so a held result is never overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
        end else if (capture) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= force_cap ? '0 : fpu_result_i;
            rsp_tag_q    <= tag_q;
        end else if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_result_o    = rsp_result_q;
    assign rsp_tag_o       = rsp_tag_q;
    assign busy_o          = in_exec;
    assign fpu_enable_o    = in_exec;
    assign fpu_stall_o     = stall;
    assign fpu_operand_a_o = op_a_q;
    assign fpu_operand_b_o = op_b_q;
    assign fpu_rm_o        = rm_q;
    assign fpu_op_o        = cmd_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed testbench for fpu_issue_ctrl. It includes a small FPU model with
// a programmable latency (in enabled, unstalled cycles).
// Each step waits for a rising clk edge plus 1 time unit, drives the inputs,
// waits 1 more time unit, and then checks the outputs.
module tb_fpu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_operand_a_i;
    logic [31:0] req_operand_b_i;
    logic [2:0]  req_rm_i;
    logic [3:0]  req_op_i;
    logic [4:0]  req_tag_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic [4:0]  rsp_tag_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        fpu_enable_o;
    logic        fpu_stall_o;
    logic [31:0] fpu_operand_a_o;
    logic [31:0] fpu_operand_b_o;
    logic [2:0]  fpu_rm_o;
    logic [3:0]  fpu_op_o;
    logic [31:0] fpu_result_i;
    logic        fpu_ready_i;
    logic        fpu_result_valid_i;

    int n_pass = 0;
    int n_chk  = 0;

    // FPU model state.
    logic [3:0] fpu_cnt;
    logic [3:0] fpu_lat;
    logic       fpu_alive;

    fpu_issue_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_operand_a_i    (req_operand_a_i),
        .req_operand_b_i    (req_operand_b_i),
        .req_rm_i           (req_rm_i),
        .req_op_i           (req_op_i),
        .req_tag_i          (req_tag_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_result_o       (rsp_result_o),
        .rsp_tag_o          (rsp_tag_o),
        .rsp_err_o          (rsp_err_o),
        .busy_o             (busy_o),
        .fpu_enable_o       (fpu_enable_o),
        .fpu_stall_o        (fpu_stall_o),
        .fpu_operand_a_o    (fpu_operand_a_o),
        .fpu_operand_b_o    (fpu_operand_b_o),
        .fpu_rm_o           (fpu_rm_o),
        .fpu_op_o           (fpu_op_o),
        .fpu_result_i       (fpu_result_i),
        .fpu_ready_i        (fpu_ready_i),
        .fpu_result_valid_i (fpu_result_valid_i)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result model: 1.0 + 2.0 = 3.0 for the single-op vector, plain integer sum otherwise.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    assign fpu_result_i       = fp_model(fpu_operand_a_o, fpu_operand_b_o);
    assign fpu_result_valid_i = fpu_alive & fpu_enable_o & (fpu_cnt == fpu_lat - 4'd1);

    // FPU model progress counter: advances on enabled, unstalled cycles and restarts after a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fpu_cnt <= '0;
        else if (!fpu_enable_o) fpu_cnt <= '0;
        else if (fpu_stall_o) fpu_cnt <= fpu_cnt;
        else if (fpu_result_valid_i) fpu_cnt <= '0;
        else fpu_cnt <= fpu_cnt + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [4:0] tag);
        req_valid_i     = v;
        req_operand_a_i = a;
        req_operand_b_i = b;
        req_op_i        = op;
        req_rm_i        = 3'd1;
        req_tag_i       = tag;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req_ready"}, req_ready_o, 1);
        chk({pfx, "_rsp_valid"}, rsp_valid_o, 0);
        chk({pfx, "_rsp_err"}, rsp_err_o, 0);
        chk({pfx, "_busy"}, busy_o, 0);
        chk({pfx, "_enable"}, fpu_enable_o, 0);
        chk({pfx, "_stall"}, fpu_stall_o, 0);
        chk({pfx, "_opa"}, fpu_operand_a_o, 0);
        chk({pfx, "_opb"}, fpu_operand_b_o, 0);
        chk({pfx, "_rm"}, {29'd0, fpu_rm_o}, 0);
        chk({pfx, "_op"}, {28'd0, fpu_op_o}, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        rsp_ready_i = 1'b1;
        fpu_ready_i = 1'b1;
        fpu_lat     = 4'd2;
        fpu_alive   = 1'b1;
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 5'd0);

        // ---- reset state ----
        cyc();
        cyc();
        settle();
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // ---- unaccepted inputs are ignored ----
        cyc();
        set_req(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 4'h3, 5'd9);
        settle();
        cyc();
        settle();
        chk("idle_no_accept_busy", busy_o, 0);
        chk("idle_no_accept_opa", fpu_operand_a_o, 0);

        // ---- single op, 2-cycle FPU ----
        cyc();                                                   // cycle 0
        set_req(1'b1, 32'h3F80_0000, 32'h4000_0000, 4'h0, 5'd7);
        settle();
        chk("s_c0_ready", req_ready_o, 1);
        chk("s_c0_enable", fpu_enable_o, 0);
        cyc();                                                   // cycle 1
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 5'd0);
        settle();
        chk("s_c1_enable", fpu_enable_o, 1);
        chk("s_c1_busy", busy_o, 1);
        chk("s_c1_ready", req_ready_o, 0);
        chk("s_c1_opa", fpu_operand_a_o, 32'h3F80_0000);
        chk("s_c1_opb", fpu_operand_b_o, 32'h4000_0000);
        chk("s_c1_rm", {29'd0, fpu_rm_o}, 1);
        cyc();                                                   // cycle 2
        settle();
        chk("s_c2_enable", fpu_enable_o, 1);
        chk("s_c2_ready_capture", req_ready_o, 1);
        chk("s_c2_rsp_valid", rsp_valid_o, 0);
        cyc();                                                   // cycle 3
        settle();
        chk("s_c3_enable", fpu_enable_o, 0);
        chk("s_c3_rsp_valid", rsp_valid_o, 1);
        chk("s_c3_result", rsp_result_o, 32'h4040_0000);
        chk("s_c3_tag", {27'd0, rsp_tag_o}, 7);
        chk("s_c3_err", rsp_err_o, 0);
        cyc();                                                   // cycle 4
        settle();
        chk("s_c4_rsp_popped", rsp_valid_o, 0);

        // ---- back-to-back, tags 1..4, req_valid held high ----
        cyc();                                                   // t0: accept tag 1
        set_req(1'b1, 32'h100, 32'h1, 4'h2, 5'd1);
        settle();
        chk("b2b_t0_ready", req_ready_o, 1);
        for (int k = 2; k <= 4; k++) begin
            cyc();                                               // odd: FPU busy
            settle();
            chk($sformatf("b2b_k%0d_ready_low", k), req_ready_o, 0);
            chk($sformatf("b2b_k%0d_rsp_valid", k), rsp_valid_o, (k > 2) ? 1 : 0);
            if (k > 2) begin
                chk($sformatf("b2b_k%0d_rsp_tag", k), {27'd0, rsp_tag_o}, k - 2);
                chk($sformatf("b2b_k%0d_rsp_res", k), rsp_result_o, ((k - 2) << 8) + (k - 2));
            end
            cyc();                                               // even: capture + accept
            set_req(1'b1, k << 8, k, 4'h2, 5'(k));
            settle();
            chk($sformatf("b2b_k%0d_ready_pulse", k), req_ready_o, 1);
            chk($sformatf("b2b_k%0d_busy", k), busy_o, 1);
        end
        cyc();                                                   // t7
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 5'd0);
        settle();
        chk("b2b_t7_rsp_tag", {27'd0, rsp_tag_o}, 3);
        chk("b2b_t7_rsp_res", rsp_result_o, 32'h303);
        cyc();                                                   // t8: capture tag 4, no accept
        settle();
        chk("b2b_t8_ready", req_ready_o, 1);
        cyc();                                                   // t9
        settle();
        chk("b2b_t9_rsp_valid", rsp_valid_o, 1);
        chk("b2b_t9_rsp_tag", {27'd0, rsp_tag_o}, 4);
        chk("b2b_t9_rsp_res", rsp_result_o, 32'h404);
        chk("b2b_t9_idle", busy_o, 0);

        // ---- backpressure on second op ----
        cyc();                                                   // t0
        set_req(1'b1, 32'h11, 32'h22, 4'h1, 5'd10);
        settle();
        cyc();                                                   // t1
        set_req(1'b1, 32'h100, 32'h200, 4'h1, 5'd11);
        settle();
        chk("bp_t1_ready", req_ready_o, 0);
        cyc();                                                   // t2: capture 10, accept 11
        settle();
        chk("bp_t2_ready", req_ready_o, 1);
        for (int i = 0; i < 6; i++) begin
            cyc();                                               // t3..t8
            set_req(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 5'd31);
            rsp_ready_i = 1'b0;
            settle();
            chk($sformatf("bp_hold%0d_stall", i), fpu_stall_o, 1);
            chk($sformatf("bp_hold%0d_opa", i), fpu_operand_a_o, 32'h100);
            chk($sformatf("bp_hold%0d_opb", i), fpu_operand_b_o, 32'h200);
            chk($sformatf("bp_hold%0d_rsp_tag", i), {27'd0, rsp_tag_o}, 10);
            chk($sformatf("bp_hold%0d_rsp_res", i), rsp_result_o, 32'h33);
            chk($sformatf("bp_hold%0d_ready", i), req_ready_o, 0);
        end
        cyc();                                                   // t9: release
        rsp_ready_i = 1'b1;
        settle();
        chk("bp_t9_stall", fpu_stall_o, 0);
        chk("bp_t9_rsp_valid", rsp_valid_o, 1);
        chk("bp_t9_rsp_tag", {27'd0, rsp_tag_o}, 10);
        cyc();                                                   // t10: capture 11
        settle();
        chk("bp_t10_rsp_valid", rsp_valid_o, 0);
        chk("bp_t10_ready", req_ready_o, 1);
        cyc();                                                   // t11
        settle();
        chk("bp_t11_rsp_tag", {27'd0, rsp_tag_o}, 11);
        chk("bp_t11_rsp_res", rsp_result_o, 32'h300);

        // ---- simultaneous capture and pop, 1-cycle FPU ----
        cyc();
        fpu_lat = 4'd1;
        settle();
        cyc();                                                   // t0: accept 20
        set_req(1'b1, 32'h5, 32'h6, 4'h0, 5'd20);
        settle();
        cyc();                                                   // t1: capture 20, accept 21
        set_req(1'b1, 32'h7, 32'h8, 4'h0, 5'd21);
        settle();
        chk("cp_t1_ready", req_ready_o, 1);
        cyc();                                                   // t2: full + capture + pop
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 5'd0);
        settle();
        chk("cp_t2_rsp_valid", rsp_valid_o, 1);
        chk("cp_t2_rsp_tag", {27'd0, rsp_tag_o}, 20);
        chk("cp_t2_rsp_res", rsp_result_o, 32'hB);
        chk("cp_t2_stall", fpu_stall_o, 0);
        chk("cp_t2_capture", req_ready_o, 1);
        cyc();                                                   // t3
        settle();
        chk("cp_t3_rsp_valid", rsp_valid_o, 1);
        chk("cp_t3_rsp_tag", {27'd0, rsp_tag_o}, 21);
        chk("cp_t3_rsp_res", rsp_result_o, 32'hF);
        chk("cp_t3_idle", busy_o, 0);
        cyc();                                                   // t4
        settle();
        chk("cp_t4_rsp_valid", rsp_valid_o, 0);

        // ---- reset mid-EXEC ----
        fpu_lat = 4'd2;
        cyc();                                                   // t0: accept 5
        set_req(1'b1, 32'hAA, 32'hBB, 4'h4, 5'd5);
        settle();
        cyc();                                                   // t1
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 5'd0);
        settle();
        chk("mr_t1_busy", busy_o, 1);
        rst_n = 1'b0;
        settle();
        chk_reset_vals("mr");
        cyc();
        rst_n = 1'b1;
        settle();
        chk("mr_after_rsp_valid", rsp_valid_o, 0);
        cyc();                                                   // t0: accept 6
        set_req(1'b1, 32'h3, 32'h4, 4'h0, 5'd6);
        settle();
        chk("mr2_t0_ready", req_ready_o, 1);
        cyc();
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 5'd0);
        settle();
        cyc();
        settle();
        chk("mr2_t2_capture", req_ready_o, 1);
        cyc();
        settle();
        chk("mr2_t3_rsp_valid", rsp_valid_o, 1);
        chk("mr2_t3_rsp_tag", {27'd0, rsp_tag_o}, 6);
        chk("mr2_t3_rsp_res", rsp_result_o, 32'h7);
        chk("mr2_t3_err", rsp_err_o, 0);

`ifdef FPU_ISSUE_TIMEOUT_EN
        // ---- watchdog: FPU never returns a result ----
        fpu_alive = 1'b0;
        cyc();                                                   // t0: accept 12
        set_req(1'b1, 32'h1, 32'h2, 4'h0, 5'd12);
        settle();
        for (int i = 1; i <= 15; i++) begin
            cyc();
            set_req(1'b0, 32'h0, 32'h0, 4'h0, 5'd0);
            settle();
        end
        chk("wd_t15_ready", req_ready_o, 0);
        cyc();                                                   // t16: forced capture
        settle();
        chk("wd_t16_busy", busy_o, 1);
        chk("wd_t16_ready", req_ready_o, 1);
        cyc();                                                   // t17
        settle();
        chk("wd_t17_rsp_valid", rsp_valid_o, 1);
        chk("wd_t17_err", rsp_err_o, 1);
        chk("wd_t17_res", rsp_result_o, 0);
        chk("wd_t17_tag", {27'd0, rsp_tag_o}, 12);
        chk("wd_t17_idle", busy_o, 0);
        fpu_alive = 1'b1;
        cyc();                                                   // normal op clears err
        set_req(1'b1, 32'h2, 32'h2, 4'h0, 5'd13);
        settle();
        cyc();
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 5'd0);
        settle();
        cyc();
        settle();
        cyc();
        settle();
        chk("wd_next_err", rsp_err_o, 0);
        chk("wd_next_res", rsp_result_o, 32'h4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
